// File: rtl/ponylink_serdes_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ponylink_serdes_bridge
// Brief    : Connects the PonyLink lane interface to OSERDES/ISERDES primitives.
//            Provides a tristate hold window, echo-aligned readback and
//            collision detection.
// Revision : 1.0 - initial release
// ============================================================================
module ponylink_serdes_bridge #(
    parameter int PARBITS       = 4,
    parameter int TRISTATE_HOLD = 3,
    parameter int ECHO_DELAY    = 2,
    parameter int ECHO_MASK     = 0,
    parameter int IN_REVERSE    = 1,
    parameter int CW            = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [PARBITS-1:0] serdes_out,
    input  logic [PARBITS-1:0] serdes_en,
    output logic [PARBITS-1:0] serdes_in,
    output logic [PARBITS-1:0] oserdes_d,
    output logic               oserdes_t,
    input  logic [PARBITS-1:0] iserdes_q,
    output logic               driving,
    output logic               collision,
    output logic [CW-1:0]      collision_count,
    input  logic               collision_clear
);
    localparam logic [3:0]    c_hold    = 4'(TRISTATE_HOLD);
    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

    logic                r_last;
    logic [3:0]          r_cnt;
    logic [PARBITS-1:0]  r_rx;
    logic [PARBITS-1:0]  r_echo_d [ECHO_DELAY];
    logic [ECHO_DELAY-1:0] r_echo_t;
    logic [PARBITS-1:0]  w_d;
    logic                w_carry;
    logic [PARBITS-1:0]  w_rx_map;
    logic [PARBITS-1:0]  w_echo_d;
    logic                w_echo_t;
    logic                w_coll;

    // Undriven lanes repeat the most recent driven bit, carried across cycles.
    always_comb begin
        w_d     = '0;
        w_carry = r_last;
        for (int i = 0; i < PARBITS; i++) begin
            if (serdes_en[i]) w_carry = serdes_out[i];
            w_d[i] = w_carry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last    <= 1'b0;
            oserdes_d <= '0;
            r_cnt     <= 4'd0;
        end else begin
            oserdes_d <= w_d;
            r_last    <= w_d[PARBITS-1];
            if (|serdes_en)
                r_cnt <= c_hold;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    assign oserdes_t = (r_cnt == 4'd0);
    assign driving   = ~oserdes_t;

    for (genvar i = 0; i < PARBITS; i++) begin : g_rx_map
        if (IN_REVERSE != 0) begin : g_rev
            assign w_rx_map[i] = iserdes_q[PARBITS-1-i];
        end else begin : g_fwd
            assign w_rx_map[i] = iserdes_q[i];
        end
    end

    // Transmit history lined up with the registered receive sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx     <= '0;
            r_echo_t <= '1;
            for (int j = 0; j < ECHO_DELAY; j++) r_echo_d[j] <= '0;
        end else begin
            r_rx        <= w_rx_map;
            r_echo_d[0] <= oserdes_d;
            r_echo_t[0] <= oserdes_t;
            for (int j = 1; j < ECHO_DELAY; j++) begin
                r_echo_d[j] <= r_echo_d[j-1];
                r_echo_t[j] <= r_echo_t[j-1];
            end
        end
    end

    assign w_echo_d = r_echo_d[ECHO_DELAY-1];
    assign w_echo_t = r_echo_t[ECHO_DELAY-1];
    assign w_coll   = ~w_echo_t && (r_rx != w_echo_d);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            collision       <= 1'b0;
            collision_count <= '0;
        end else begin
            collision <= w_coll;
            if (collision_clear)
                collision_count <= collision ? CW'(1) : '0;
            else if (collision && collision_count != c_cnt_max)
                collision_count <= collision_count + CW'(1);
        end
    end

    if (ECHO_MASK != 0) begin : g_mask
        assign serdes_in = w_echo_t ? r_rx : w_echo_d;
    end else begin : g_nomask
        assign serdes_in = r_rx;
    end

endmodule
`default_nettype wire

// File: tb/tb_ponylink_serdes_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ponylink_serdes_bridge
// Brief    : Self-checking bench; two bridge instances against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ponylink_serdes_bridge;
    localparam int ED   = 2;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] serdes_out = '0, serdes_en = '0, q0 = '0, q1 = '0;
    logic       collision_clear = 1'b0;
    logic [3:0] sin0, od0, sin1, od1;
    logic       t0, t1, drv0, drv1, col0, col1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [18:0] act0, act1;

    always #5 clk = ~clk;

    ponylink_serdes_bridge dut0 (
        .clk(clk), .resetn(resetn), .serdes_out(serdes_out), .serdes_en(serdes_en),
        .serdes_in(sin0), .oserdes_d(od0), .oserdes_t(t0), .iserdes_q(q0),
        .driving(drv0), .collision(col0), .collision_count(cnt0),
        .collision_clear(collision_clear));

    ponylink_serdes_bridge #(.IN_REVERSE(0), .ECHO_MASK(1), .CW(2)) dut1 (
        .clk(clk), .resetn(resetn), .serdes_out(serdes_out), .serdes_en(serdes_en),
        .serdes_in(sin1), .oserdes_d(od1), .oserdes_t(t1), .iserdes_q(q1),
        .driving(drv1), .collision(col1), .collision_count(cnt1),
        .collision_clear(collision_clear));

    assign act0 = {od0, t0, drv0, sin0, col0, cnt0};
    assign act1 = {od1, t1, drv1, sin1, col1, 6'd0, cnt1};

    // Model: per-edge history of what the line should carry and what comes back.
    int         n, last_en, mcnt0, mcnt1;
    logic       m_last;
    logic [3:0] hd [0:1023];
    logic       ht [0:1023];
    logic [3:0] hrx0 [0:1023];
    logic [3:0] hrx1 [0:1023];
    logic       hc0 [0:1023];
    logic       hc1 [0:1023];
    logic       loopback;
    logic [3:0] inject;
    int         n_checks = 0, n_fail = 0;
    logic [18:0] c_rst_vec;

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [3:0] echo_d(input int k);
        return (k - ED >= 1) ? hd[k-ED] : 4'b0000;
    endfunction

    function automatic logic echo_t(input int k);
        return (k - ED >= 1) ? ht[k-ED] : 1'b1;
    endfunction

    function automatic logic [18:0] exp_vec(input int c);
        logic [3:0] s;
        if (c == 0) s = hrx0[n];
        else        s = echo_t(n) ? hrx1[n] : echo_d(n);
        return {hd[n], ht[n], ~ht[n], s, (c == 0) ? hc0[n] : hc1[n],
                (c == 0) ? 8'(mcnt0) : 8'(mcnt1)};
    endfunction

    task automatic reset_model();
        n = 0; last_en = -100; m_last = 1'b0; mcnt0 = 0; mcnt1 = 0;
        hd[0] = '0; ht[0] = 1'b1; hrx0[0] = '0; hrx1[0] = '0; hc0[0] = 1'b0; hc1[0] = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] d;
        logic found;
        n++;
        // Each lane shows the value of the nearest enabled lane at or below it.
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            d[i]  = m_last;
            for (int j = i; j >= 0; j--)
                if (!found && serdes_en[j]) begin d[i] = serdes_out[j]; found = 1'b1; end
        end
        hd[n] = d; m_last = d[3];
        if (|serdes_en) last_en = n;
        ht[n]   = !((n - last_en) < HOLD);
        hrx0[n] = rev4(q0);
        hrx1[n] = q1;
        if (collision_clear) begin
            mcnt0 = hc0[n-1] ? 1 : 0;
            mcnt1 = hc1[n-1] ? 1 : 0;
        end else begin
            if (hc0[n-1] && mcnt0 < 255) mcnt0++;
            if (hc1[n-1] && mcnt1 < 3)   mcnt1++;
        end
        hc0[n] = !echo_t(n-1) && (hrx0[n-1] != echo_d(n-1));
        hc1[n] = !echo_t(n-1) && (hrx1[n-1] != echo_d(n-1));
    endtask

    task automatic step(input logic [3:0] en, input logic [3:0] dout, input logic clr);
        logic [3:0] want;
        serdes_en = en; serdes_out = dout; collision_clear = clr;
        if (loopback) begin
            want = ((n + 1 - ED) >= 1) ? hd[n+1-ED] : 4'b0000;
            want = want ^ inject;
            q0 = rev4(want);
            q1 = want;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        serdes_en = '0; serdes_out = '0; collision_clear = 1'b0; q0 = '0; q1 = '0;
        loopback = 1'b0; inject = '0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        serdes_en = 4'b1111; serdes_out = 4'b1111; q0 = 4'b1111; q1 = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        if (act0 !== c_rst_vec) begin $display("FAIL reset_dut0 got=%h want=%h", act0, c_rst_vec); n_fail++; end
        n_checks++;
        if (act1 !== c_rst_vec) begin $display("FAIL reset_dut1 got=%h want=%h", act1, c_rst_vec); n_fail++; end
        n_checks++;
    endtask

    task automatic test_transmit();
        do_reset();
        step(4'b0100, 4'b0100, 1'b0);
        if (od0 !== 4'b1100 || t0 !== 1'b0) begin
            $display("FAIL tx_first od=%b t=%b want od=1100 t=0", od0, t0); n_fail++;
        end
        n_checks++;
        for (int c = 2; c <= 5; c++) begin
            step(4'b0000, 4'b0000, 1'b0);
            if (od0 !== 4'b1111 || t0 !== (c > HOLD)) begin
                $display("FAIL tx_hold cyc=%0d od=%b t=%b want od=1111 t=%b", c, od0, t0, c > HOLD);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_window_extend();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            step((c == 0 || c == 2) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
            if (od0 !== 4'b0000 || t0 !== (c >= 5)) begin
                $display("FAIL window_ext cyc=%0d od=%b t=%b want od=0000 t=%b", c + 1, od0, t0, c >= 5);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_in_reverse();
        do_reset();
        q0 = 4'b0001; q1 = 4'b0001;
        step(4'b0000, 4'b0000, 1'b0);
        if (sin0 !== 4'b1000) begin $display("FAIL in_reverse got=%b want=1000", sin0); n_fail++; end
        n_checks++;
        if (sin1 !== 4'b0001) begin $display("FAIL in_forward got=%b want=0001", sin1); n_fail++; end
        n_checks++;
    endtask

    task automatic test_collision();
        do_reset();
        loopback = 1'b1;
        step(4'b1111, 4'b1010, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step(4'b0000, 4'b0000, 1'b0);
            if (col0 !== 1'b0 || col1 !== 1'b0 || cnt0 !== 8'd0) begin
                $display("FAIL clean_echo cyc=%0d col=%b%b cnt=%0d want col=00 cnt=0", c, col0, col1, cnt0);
                n_fail++;
            end
            n_checks++;
        end
        do_reset();
        loopback = 1'b1;
        step(4'b1111, 4'b1010, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        inject = 4'b0001;
        step(4'b0000, 4'b0000, 1'b0);
        inject = 4'b0000;
        if (sin1 !== 4'b1010 || sin0 !== 4'b1011) begin
            $display("FAIL echo_mask sin1=%b sin0=%b want sin1=1010 sin0=1011", sin1, sin0); n_fail++;
        end
        n_checks++;
        step(4'b0000, 4'b0000, 1'b0);
        if (col0 !== 1'b1 || col1 !== 1'b1) begin
            $display("FAIL coll_pulse got=%b%b want=11", col0, col1); n_fail++;
        end
        n_checks++;
        step(4'b0000, 4'b0000, 1'b0);
        if (col0 !== 1'b0 || cnt0 !== 8'd1 || cnt1 !== 2'd1) begin
            $display("FAIL coll_count col=%b cnt0=%0d cnt1=%0d want col=0 cnt=1", col0, cnt0, cnt1); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_saturate();
        do_reset();
        loopback = 1'b1; inject = 4'b0001;
        repeat (9) step(4'b1111, 4'b0110, 1'b0);
        if (cnt1 !== 2'd3 || cnt0 !== 8'd5) begin
            $display("FAIL saturate cnt1=%0d cnt0=%0d want cnt1=3 cnt0=5", cnt1, cnt0); n_fail++;
        end
        n_checks++;
        step(4'b1111, 4'b0110, 1'b1);
        if (cnt1 !== 2'd1 || cnt0 !== 8'd1) begin
            $display("FAIL clear_with_coll cnt1=%0d cnt0=%0d want 1", cnt1, cnt0); n_fail++;
        end
        n_checks++;
        inject = 4'b0000;
        step(4'b1111, 4'b0110, 1'b0);
        step(4'b1111, 4'b0110, 1'b0);
        if (act1 !== exp_vec(1)) begin $display("FAIL sat_model got=%h want=%h", act1, exp_vec(1)); n_fail++; end
        n_checks++;
        step(4'b1111, 4'b0110, 1'b1);
        if (cnt1 !== 2'd0 || cnt0 !== 8'd0) begin
            $display("FAIL clear_alone cnt1=%0d cnt0=%0d want 0", cnt1, cnt0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        loopback = 1'b1; inject = 4'b0100;
        step(4'b1000, 4'b1000, 1'b0);
        repeat (5) step(4'b1111, 4'b1111, 1'b0);
        if (t0 !== 1'b0 || cnt0 === 8'd0) begin
            $display("FAIL pre_reset t=%b cnt=%0d want t=0 cnt>0", t0, cnt0); n_fail++;
        end
        n_checks++;
        #3;
        resetn = 1'b0;
        #1;
        if (act0 !== c_rst_vec) begin $display("FAIL async_reset_dut0 got=%h want=%h", act0, c_rst_vec); n_fail++; end
        n_checks++;
        if (act1 !== c_rst_vec) begin $display("FAIL async_reset_dut1 got=%h want=%h", act1, c_rst_vec); n_fail++; end
        n_checks++;
        do_reset();
        step(4'b0100, 4'b0100, 1'b0);
        if (od0 !== 4'b1100) begin $display("FAIL post_reset_last got=%b want=1100", od0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            loopback = ($urandom_range(0, 3) != 0);
            inject   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            q0 = 4'($urandom); q1 = 4'($urandom);
            step(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 4'($urandom),
                 $urandom_range(0, 15) == 0);
            if (act0 !== exp_vec(0)) begin
                $display("FAIL random_dut0 cyc=%0d got=%h want=%h", c, act0, exp_vec(0)); n_fail++;
            end
            n_checks++;
            if (act1 !== exp_vec(1)) begin
                $display("FAIL random_dut1 cyc=%0d got=%h want=%h", c, act1, exp_vec(1)); n_fail++;
            end
            n_checks++;
        end
    endtask

    initial begin
        c_rst_vec = {4'd0, 1'b1, 14'd0};
        loopback  = 1'b0;
        inject    = 4'b0000;
        reset_model();
        test_reset();
        test_transmit();
        test_window_extend();
        test_in_reverse();
        test_collision();
        test_saturate();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
